adder_8bit: RTL and testbench
=============================

Name: adder_8bit

Overview:
- Registered 8-bit two's-complement / unsigned adder used as the add path of the 8-bit ALU.
- Computes a + b through a ripple-carry chain of eight full-adder cells.
- Registers the 8-bit sum, the unsigned carry-out and the signed overflow flag on the rising clock edge.
- Output flags feed the ALU status logic.

Parameters:
- WIDTH, 8, operand/result width. Only 8 is supported and verified; overflow and carry are defined on bit WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- a  input  8  operand A (unsigned or two's complement).
- b  input  8  operand B.
- sub  input  1  subtract select. Present only when ADDER8_SUB_EN is defined.
- sum  output  8  registered result bits [7:0].
- carry  output  1  registered carry-out of bit 7.
- overflow  output  1  registered signed-overflow flag.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- While reset = 1, independent of clk: sum = 8'h00, carry = 0, overflow = 0. The outputs hold these values until the first rising clk edge after reset deasserts.
- Datapath is a ripple chain of 8 full-adder cells:
  - s[i] = a[i] ^ b'[i] ^ c[i]
  - c[i+1] = a[i]&b'[i] | a[i]&c[i] | b'[i]&c[i]
  - c[0] = cin
  - Without subtraction: b' = b and cin = 0.
- Combinational results:
  - raw sum = s[7:0]
  - raw carry = c[8]
  - raw overflow = (a[7] == b'[7]) && (s[7] != a[7]); equivalently c[8] ^ c[7].
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on sum/carry/overflow after edge N. The registers load every cycle; there is no enable and no handshake.
- Inputs must be stable for setup/hold around the clk edge. Mid-cycle input changes are not visible on the outputs until the next edge.
- Wrap-around:
  - The sum is modulo 256.
  - carry = 1 iff the unsigned result is ≥ 256.
  - overflow = 1 iff two same-sign operands produce a result of the opposite sign.
- Reset asserted mid-operation clears the outputs immediately. The operand presented in that cycle is discarded and not replayed.
- Reset deasserting coincident with a clk edge: the outputs remain 0 for that edge; loading starts at the next edge.
- No X propagation requirement beyond standard: X on inputs may produce X on outputs only after the next edge.

Optional Feature:
- Macro: ADDER8_SUB_EN.
- Defined:
  - Port sub exists.
  - sub = 1 computes a - b as a + ~b + 1 (b' = ~b, cin = 1).
  - carry = c[8], i.e. 1 means no borrow.
  - overflow uses b' = ~b, so it flags signed subtraction overflow.
  - sub = 0 behaves identically to the add-only build.
- Not defined: no sub port; b' = b and cin = 0 are hard-wired. Gate count and behaviour equal the add-only datapath.

Test Plan:
- Assert reset with a = 8'hFF, b = 8'hFF, toggling clk -> sum = 8'h00, carry = 0, overflow = 0 immediately and throughout reset.
- a = 8'h01, b = 8'h01, then a = 8'h02, b = 8'h03, then a = 8'h19, b = 8'h31 on consecutive edges -> one cycle later each, sum = 8'h02, 8'h05, 8'h4A respectively; carry = 0 and overflow = 0 for all three.
- a = 8'h81, b = 8'h81 -> sum = 8'h02, carry = 1, overflow = 1. Then a = 8'h7F, b = 8'h01 -> sum = 8'h80, carry = 0, overflow = 1.
- a = 8'hFF, b = 8'h01 -> sum = 8'h00, carry = 1, overflow = 0. a = 8'hFF, b = 8'h00 -> sum = 8'hFF, carry = 0, overflow = 0. a = 8'hFF, b = 8'hFF -> sum = 8'hFE, carry = 1, overflow = 0.
- Apply a = 8'h03, b = 8'h03, then assert reset asynchronously mid-cycle before the next edge -> outputs go to 0 at once. Release reset; the next edge with a = 8'h03, b = 8'h03 gives sum = 8'h06, carry = 0, overflow = 0.
- With ADDER8_SUB_EN defined:
  - sub = 1, a = 8'h05, b = 8'h03 -> sum = 8'h02, carry = 1, overflow = 0.
  - a = 8'h80, b = 8'h01 -> sum = 8'h7F, carry = 1, overflow = 1.
  - a = 8'h00, b = 8'h01 -> sum = 8'hFF, carry = 0, overflow = 0.

Source files
------------

// File: rtl/adder_8bit.sv
// Registered ripple-carry adder: sum, carry-out and signed overflow, one-cycle latency.
// Define ADDER8_SUB_EN to add the sub port (a - b computed as a + ~b + 1).
`timescale 1ns/1ps
module adder_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef ADDER8_SUB_EN
   input  logic             sub,
`endif
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff;
   logic             cin;
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;

   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   always_comb begin
`ifdef ADDER8_SUB_EN
      b_eff = sub ? ~b : b;
      cin   = sub;
`else
      b_eff = b;
      cin   = 1'b0;
`endif
   end

   // Explicit full-adder cells so the chain stays a ripple structure.
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int i = 0; i < WIDTH; i++) begin
         s[i]   = a[i] ^ b_eff[i] ^ c[i];
         c[i+1] = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
      end
   end

   always_comb begin
      sum_d   = s;
      carry_d = c[WIDTH];
      ovf_d   = c[WIDTH] ^ c[WIDTH-1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign sum      = sum_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_8bit.sv
// Scoreboard bench for adder_8bit: driver queues hand-computed results, monitor checks them.
`timescale 1ns/1ps
module tb_adder_8bit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] a = 8'hFF;
   logic [7:0] b = 8'hFF;
`ifdef ADDER8_SUB_EN
   logic       sub = 1'b0;
`endif
   logic [7:0] sum;
   logic       carry;
   logic       overflow;

   logic [9:0] exp_q[$];
   int         id_q[$];
   int         checks = 0;
   int         errors = 0;
   logic       fin_flag = 1'b0;
   event       chk_ev;

   always #5 clk = ~clk;

   adder_8bit #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .a        (a),
      .b        (b),
`ifdef ADDER8_SUB_EN
      .sub      (sub),
`endif
      .sum      (sum),
      .carry    (carry),
      .overflow (overflow)
   );

   // Monitor: wakes after each rising edge (or an immediate-check event) and pops one expectation.
   always begin
      logic [9:0] e;
      int         id;
      @(posedge clk or chk_ev);
      #1;
      if (fin_flag) begin
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
         end
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end else if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         id = id_q.pop_front();
         checks++;
         if ({sum, carry, overflow} !== e) begin
            errors++;
            $display("FAIL vec%0d: got sum=%h carry=%b ovf=%b, required sum=%h carry=%b ovf=%b",
                     id, sum, carry, overflow, e[9:2], e[1], e[0]);
         end
      end
   end

   task automatic expect_out(input int id, input logic [7:0] s, input logic c, input logic v);
      exp_q.push_back({s, c, v});
      id_q.push_back(id);
   endtask

   task automatic drive(input int id, input logic [7:0] av, input logic [7:0] bv,
                        input logic sb, input logic [7:0] s, input logic c, input logic v);
      @(negedge clk);
      a = av;
      b = bv;
`ifdef ADDER8_SUB_EN
      sub = sb;
`else
      if (sb) $display("note: sub vector %0d issued on add-only build", id);
`endif
      expect_out(id, s, c, v);
   endtask

   initial begin
      // Reset held with all-ones operands: outputs zero immediately and across edges.
      #2;
      expect_out(0, 8'h00, 1'b0, 1'b0);
      -> chk_ev;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         expect_out(i, 8'h00, 1'b0, 1'b0);
      end
      @(negedge clk);
      reset = 1'b0;

      drive(10, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      drive(11, 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);
      drive(12, 8'h19, 8'h31, 1'b0, 8'h4A, 1'b0, 1'b0);
      drive(13, 8'h81, 8'h81, 1'b0, 8'h02, 1'b1, 1'b1);
      drive(14, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      drive(15, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      drive(16, 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0);
      drive(17, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);
      drive(18, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1);
      drive(19, 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0);

      // Async reset mid-cycle: outputs clear before any edge, operand is discarded.
      @(negedge clk);
      a = 8'h03;
      b = 8'h03;
      #1 reset = 1'b1;
      #1;
      expect_out(20, 8'h00, 1'b0, 1'b0);
      -> chk_ev;
      @(negedge clk);
      expect_out(21, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      expect_out(22, 8'h06, 1'b0, 1'b0);

`ifdef ADDER8_SUB_EN
      drive(30, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
      drive(31, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
      drive(32, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
      drive(33, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
`endif

      repeat (3) @(negedge clk);
      fin_flag = 1'b1;
      #2 -> chk_ev;
      #100;
      $display("FAIL timeout: monitor did not reach summary, required summary");
      $fatal(1, "bench stalled");
   end

endmodule
